mips_harvard_mem_bridge: RTL and testbench

MIPS_HARVARD_MEM_BRIDGE -- requirements
Module: mips_harvard_mem_bridge

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/mips_sram_sp.sv | 24 ++
 rtl/mips_harvard_mem_bridge.sv | 132 +++++++++++++
 tb/tb_mips_harvard_mem_bridge.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS Harvard-to-single-SRAM bridge.
// Both CPU regions live in one 512-word SRAM: RAM in the low half, ROM in the high half.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    StIRd,
    StILat,
    StDRd,
    StDLat,
    StDWr,
    StRun
  } mem_state_e;

  localparam logic [31:0] DefaultRomBase = 32'hBFC0_0000;
  localparam logic [31:0] DefaultRamBase = 32'h0000_0000;
  localparam int unsigned RegionWords    = 256;
  localparam int unsigned SramWords      = 2 * RegionWords;
  localparam int unsigned SramAddrWidth  = $clog2(SramWords);

  // Byte offset of an address from a region base; in-region iff the offset is below 1 KiB.
  function automatic logic [31:0] region_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/mips_sram_sp.sv
// Single-port synchronous SRAM, one-cycle read latency, no reset.
// A read during a write returns the old contents.
module mips_sram_sp #(
  parameter int unsigned Depth     = 512,
  parameter int unsigned Width     = 32,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr,
  input  logic [Width-1:0]     wdata,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mips_harvard_mem_bridge.sv
// Serialises a MIPS CPU's instruction and data ports onto one single-port SRAM,
// stalling the CPU via clk_enable until each fetch/load/store has completed.
module mips_harvard_mem_bridge
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] ROM_BASE = DefaultRomBase,
  parameter logic [31:0] RAM_BASE = DefaultRamBase
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  input  logic        ld_en,
  input  logic [8:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic        bus_err
);

  mem_state_e state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] i_off, d_off;
  logic        i_hit, d_hit;
  logic        unused_addr_bits;

  logic                     sram_we;
  logic [SramAddrWidth-1:0] sram_addr;
  logic [31:0]              sram_wdata;
  logic [31:0]              sram_rdata;

  assign i_off = region_offset(instr_address, ROM_BASE);
  assign d_off = region_offset(data_address, RAM_BASE);
  assign i_hit = (i_off[31:10] == '0);
  assign d_hit = (d_off[31:10] == '0);
  assign unused_addr_bits = ^{i_off[1:0], d_off[1:0]};

  // While reset is held the SRAM belongs to the preload port; nothing else may write it.
  always_comb begin
    sram_we    = 1'b0;
    sram_addr  = {1'b1, i_off[9:2]};
    sram_wdata = data_writedata;
    if (!reset) begin
      sram_we    = ld_en;
      sram_addr  = ld_addr;
      sram_wdata = ld_data;
    end else begin
      unique case (state_q)
        StDRd: sram_addr = {1'b0, d_off[9:2]};
        StDWr: begin
          sram_addr = {1'b0, d_off[9:2]};
          sram_we   = d_hit;
        end
        default: sram_addr = {1'b1, i_off[9:2]};
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIRd: state_d = StILat;
      StILat: begin
        instr_d = i_hit ? sram_rdata : '0;
        // A fetch from address 0 is a benign null read, not an access error.
        if (!i_hit && (instr_address != '0)) begin
          err_d = 1'b1;
        end
        if ((data_read && data_write) || ((data_read || data_write) && !d_hit)) begin
          err_d = 1'b1;
        end
        if (data_read) begin
          state_d = StDRd;
        end else if (data_write) begin
          state_d = StDWr;
        end else begin
          state_d = StRun;
        end
      end
      StDRd: state_d = StDLat;
      StDLat: begin
        rdata_d = d_hit ? sram_rdata : '0;
        state_d = StRun;
      end
      StDWr:   state_d = StRun;
      StRun:   state_d = StIRd;
      default: state_d = StIRd;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIRd;
      instr_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign instr_readdata = instr_q;
  assign data_readdata  = rdata_q;
  assign bus_err        = err_q;
  assign clk_enable     = (state_q == StRun);

  mips_sram_sp #(
    .Depth    (SramWords),
    .Width    (32),
    .AddrWidth(SramAddrWidth)
  ) u_sram (
    .clk  (clk),
    .we   (sram_we),
    .addr (sram_addr),
    .wdata(sram_wdata),
    .rdata(sram_rdata)
  );

endmodule

// File: tb/tb_mips_harvard_mem_bridge.sv
// Directed bench for mips_harvard_mem_bridge: the bench plays the CPU, changing its
// request only in the clk_enable cycle, and checks data, error flag and stall lengths.
module tb_mips_harvard_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        clk_enable;
  logic        ld_en;
  logic [8:0]  ld_addr;
  logic [31:0] ld_data;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  mips_harvard_mem_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .instr_address (instr_address),
    .instr_readdata(instr_readdata),
    .data_address  (data_address),
    .data_read     (data_read),
    .data_write    (data_write),
    .data_writedata(data_writedata),
    .data_readdata (data_readdata),
    .clk_enable    (clk_enable),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .bus_err       (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count posedges until clk_enable is seen high (sampled at negedge); 20 means timeout.
  task automatic wait_ce(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end while (!clk_enable && cnt < 20);
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_clears_err", {31'b0, bus_err}, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    instr_address  = 32'hBFC0_0000;
    data_address   = '0;
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_writedata = '0;
    ld_en          = 1'b0;
    ld_addr        = '0;
    ld_data        = '0;
    #1;
    check("rst_instr", instr_readdata, 32'd0);
    check("rst_data", data_readdata, 32'd0);
    check("rst_err", {31'b0, bus_err}, 32'd0);
    check("rst_ce", {31'b0, clk_enable}, 32'd0);

    @(negedge clk);
    preload(9'd256, 32'h2402_0005);
    preload(9'd257, 32'h8C43_0010);
    preload(9'd4, 32'hDEAD_BEEF);
    preload(9'd2, 32'hAAAA_AAAA);
    preload(9'd0, 32'h1111_1111);

    // Fetch-only loop; ld_en left high to prove preload is ignored out of reset.
    ld_en   = 1'b1;
    ld_addr = 9'd4;
    ld_data = 32'h0;
    reset   = 1'b1;
    wait_ce(n);
    check("first_ce_edges", n, 32'd2);
    check("fetch_rom0", instr_readdata, 32'h2402_0005);
    wait_ce(n);
    check("fetch_period", n, 32'd3);
    wait_ce(n);
    check("fetch_period2", n, 32'd3);
    check("no_err_fetch", {31'b0, bus_err}, 32'd0);

    // Load 0x10 while fetching the second ROM word.
    instr_address = 32'hBFC0_0004;
    data_read     = 1'b1;
    data_address  = 32'h10;
    wait_ce(n);
    check("load_period", n, 32'd5);
    check("load_data", data_readdata, 32'hDEAD_BEEF);
    check("fetch_rom1", instr_readdata, 32'h8C43_0010);

    // Store then load back.
    instr_address  = 32'hBFC0_0000;
    data_read      = 1'b0;
    data_write     = 1'b1;
    data_address   = 32'h8;
    data_writedata = 32'h1234_5678;
    wait_ce(n);
    check("store_period", n, 32'd4);
    check("hold_data", data_readdata, 32'hDEAD_BEEF);
    data_write = 1'b0;
    data_read  = 1'b1;
    wait_ce(n);
    check("load_after_store", data_readdata, 32'h1234_5678);
    check("no_err_store", {31'b0, bus_err}, 32'd0);

    // Null fetch at address 0.
    instr_address = 32'h0;
    data_read     = 1'b0;
    wait_ce(n);
    check("null_fetch_period", n, 32'd3);
    check("null_fetch_data", instr_readdata, 32'd0);
    check("null_fetch_err", {31'b0, bus_err}, 32'd0);

    // Load and store together: load wins, store dropped, error flagged.
    instr_address  = 32'hBFC0_0000;
    data_read      = 1'b1;
    data_write     = 1'b1;
    data_address   = 32'h10;
    data_writedata = 32'h5555_5555;
    wait_ce(n);
    check("both_period", n, 32'd5);
    check("both_load", data_readdata, 32'hDEAD_BEEF);
    check("both_err", {31'b0, bus_err}, 32'd1);
    data_write = 1'b0;
    wait_ce(n);
    check("both_no_write", data_readdata, 32'hDEAD_BEEF);
    check("err_sticky", {31'b0, bus_err}, 32'd1);

    ld_en = 1'b0;
    pulse_reset();

    // Fetch outside ROM, then store and load outside RAM.
    instr_address = 32'h0000_1000;
    data_read     = 1'b0;
    wait_ce(n);
    check("bad_fetch_data", instr_readdata, 32'd0);
    check("bad_fetch_err", {31'b0, bus_err}, 32'd1);
    instr_address  = 32'hBFC0_0000;
    data_write     = 1'b1;
    data_address   = 32'h400;
    data_writedata = 32'h9999_9999;
    wait_ce(n);
    check("bad_store_period", n, 32'd4);
    data_write   = 1'b0;
    data_read    = 1'b1;
    data_address = 32'h0;
    wait_ce(n);
    check("bad_store_no_alias", data_readdata, 32'h1111_1111);
    data_address = 32'h400;
    wait_ce(n);
    check("bad_load_data", data_readdata, 32'd0);
    check("bad_err_sticky", {31'b0, bus_err}, 32'd1);

    pulse_reset();

    // Reset asserted while in the store state.
    instr_address = 32'hBFC0_0004;
    data_read     = 1'b1;
    data_address  = 32'h10;
    wait_ce(n);
    check("pre_abort_load", data_readdata, 32'hDEAD_BEEF);
    data_read      = 1'b0;
    data_write     = 1'b1;
    data_address   = 32'h8;
    data_writedata = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ce", {31'b0, clk_enable}, 32'd0);
    check("abort_instr", instr_readdata, 32'd0);
    check("abort_data", data_readdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    data_write = 1'b0;
    data_read  = 1'b1;
    reset      = 1'b1;
    wait_ce(n);
    check("restart_from_fetch", n, 32'd4);
    check("abort_no_write", data_readdata, 32'h1234_5678);
    check("abort_fetch", instr_readdata, 32'h8C43_0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
